// File: rtl/maquina_pkg.sv
// Shared state codes and default sizing for the coffee-machine sequencer.
`default_nettype none

package maquina_pkg;

   localparam int STATE_W = 4;
   typedef logic [STATE_W-1:0] state_t;

   localparam logic [3:0] ST_IDLE                = 4'd0;
   localparam logic [3:0] ST_LIGAR               = 4'd1;
   localparam logic [3:0] ST_VERIFICAR_AGUA      = 4'd2;
   localparam logic [3:0] ST_ENCHER_RESERVATORIO = 4'd3;
   localparam logic [3:0] ST_MOER_CAFE           = 4'd4;
   localparam logic [3:0] ST_COLOCAR_NO_FILTRO   = 4'd5;
   localparam logic [3:0] ST_PASSAR_AGITADOR     = 4'd6;
   localparam logic [3:0] ST_ESQUENTAR_AGUA      = 4'd7;
   localparam logic [3:0] ST_DESPEJAR            = 4'd8;
   localparam logic [3:0] ST_FINAL               = 4'd9;
   localparam logic [3:0] ST_ABORTADO            = 4'd10;

   localparam int DEF_STEP_CYCLES = 4;
   localparam int DEF_RES_CAP     = 8;
   localparam int DEF_CUP_COST    = 2;
   localparam int DEF_FILL_RATE   = 1;
   localparam int DEF_MAX_CUPS    = 4;
   localparam int DEF_CUPS_W      = 3;

endpackage

`default_nettype wire

// File: rtl/maquina_cafe_param_step_timer.sv
// Dwell counter for timed steps: cleared on state entry, tc marks the last cycle.
`default_nettype none

module step_timer
   import maquina_pkg::*;
#(
   parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tc
);

   localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (tc) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/maquina_cafe_param.sv
// Parametrised coffee-machine brew sequencer with reservoir tracking,
// abort, busy/done/err handshake and per-brew cup counter.
`default_nettype none

module maquina_cafe_param
   import maquina_pkg::*;
#(
   parameter int STEP_CYCLES = DEF_STEP_CYCLES,
   parameter int RES_CAP     = DEF_RES_CAP,
   parameter int CUP_COST    = DEF_CUP_COST,
   parameter int FILL_RATE   = DEF_FILL_RATE,
   parameter int MAX_CUPS    = DEF_MAX_CUPS,
   parameter int CUPS_W      = DEF_CUPS_W,
   localparam int LVL_W      = $clog2(RES_CAP + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CUPS_W-1:0] cups,
   input  logic              abort,
   output logic [3:0]        state,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LVL_W-1:0]  level,
   output logic [CUPS_W-1:0] cups_made
);

   localparam int NEED_W   = LVL_W + CUPS_W;
   // A fill step larger than the tank behaves like a single-cycle top-up.
   localparam int FILL_EFF = (FILL_RATE > RES_CAP) ? RES_CAP : FILL_RATE;
   localparam logic [CUPS_W-1:0] MAX_CUPS_V = CUPS_W'(MAX_CUPS);
   localparam logic [LVL_W-1:0]  CAP_V      = LVL_W'(RES_CAP);
   localparam logic [LVL_W-1:0]  COST_V     = LVL_W'(CUP_COST);

   if (MAX_CUPS * CUP_COST > RES_CAP) begin : g_chk_water
      $error("maquina_cafe_param: MAX_CUPS*CUP_COST exceeds RES_CAP");
   end
   if (MAX_CUPS >= (1 << CUPS_W)) begin : g_chk_cups_w
      $error("maquina_cafe_param: CUPS_W too narrow for MAX_CUPS");
   end
   if (STEP_CYCLES < 1 || FILL_RATE < 1) begin : g_chk_rates
      $error("maquina_cafe_param: STEP_CYCLES and FILL_RATE must be >= 1");
   end

   logic [3:0]        state_nx;
   logic [LVL_W-1:0]  level_nx;
   logic [CUPS_W-1:0] cups_req;
   logic [CUPS_W-1:0] cups_req_nx;
   logic [CUPS_W-1:0] cups_made_nx;
   logic [CUPS_W-1:0] made_inc;
   logic              err_nx;
   logic              tc;
   logic              cups_ok;
   logic              abortable;
   logic [NEED_W-1:0] need;
   logic [LVL_W:0]    fill_sum;
   logic [LVL_W-1:0]  fill_lvl;

   assign need      = NEED_W'(cups_req) * NEED_W'(CUP_COST);
   assign fill_sum  = {1'b0, level} + (LVL_W + 1)'(FILL_EFF);
   assign fill_lvl  = (fill_sum >= {1'b0, CAP_V}) ? CAP_V : fill_sum[LVL_W-1:0];
   assign made_inc  = cups_made + CUPS_W'(1);
   assign cups_ok   = (cups != '0) && (cups <= MAX_CUPS_V);
   assign abortable = (state >= ST_LIGAR) && (state <= ST_DESPEJAR);

   step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_step_timer (
      .clk  (clk),
      .rst  (rst),
      .clear(state_nx != state),
      .tc   (tc)
   );

   always_comb begin
      state_nx     = state;
      level_nx     = level;
      cups_req_nx  = cups_req;
      cups_made_nx = cups_made;
      err_nx       = 1'b0;
      // Abort wins over any step transition and freezes water and cup count.
      if (abortable && abort) begin
         state_nx = ST_ABORTADO;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (cups_ok) begin
                     cups_req_nx  = cups;
                     cups_made_nx = '0;
                     state_nx     = ST_LIGAR;
                  end else begin
                     err_nx = 1'b1;
                  end
               end
            end
            ST_LIGAR:             if (tc) state_nx = ST_VERIFICAR_AGUA;
            ST_VERIFICAR_AGUA: begin
               if (need <= NEED_W'(level)) state_nx = ST_MOER_CAFE;
               else                        state_nx = ST_ENCHER_RESERVATORIO;
            end
            ST_ENCHER_RESERVATORIO: begin
               level_nx = fill_lvl;
               if (fill_lvl == CAP_V) state_nx = ST_VERIFICAR_AGUA;
            end
            ST_MOER_CAFE:         if (tc) state_nx = ST_COLOCAR_NO_FILTRO;
            ST_COLOCAR_NO_FILTRO: if (tc) state_nx = ST_PASSAR_AGITADOR;
            ST_PASSAR_AGITADOR:   if (tc) state_nx = ST_ESQUENTAR_AGUA;
            ST_ESQUENTAR_AGUA:    if (tc) state_nx = ST_DESPEJAR;
            ST_DESPEJAR: begin
               // Staying here relies on the timer wrapping to start the next cup.
               if (tc) begin
                  level_nx     = level - COST_V;
                  cups_made_nx = made_inc;
                  if (made_inc == cups_req) state_nx = ST_FINAL;
               end
            end
            ST_FINAL:             state_nx = ST_IDLE;
            ST_ABORTADO:          state_nx = ST_IDLE;
            default:              state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         level     <= '0;
         cups_req  <= '0;
         cups_made <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         level     <= level_nx;
         cups_req  <= cups_req_nx;
         cups_made <= cups_made_nx;
         err       <= err_nx;
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_FINAL);

endmodule

`default_nettype wire

// File: tb/tb_maquina_cafe_param.sv
// Scoreboard bench for maquina_cafe_param: timeline reference model, randomized brews/aborts.
`default_nettype none

module tb_maquina_cafe_param;

   localparam int S     = 4;
   localparam int CAP   = 8;
   localparam int COST  = 2;
   localparam int FR    = 1;
   localparam int MAXC  = 4;
   localparam int CW    = 3;
   localparam int LW    = $clog2(CAP + 1);

   typedef struct {
      int kind;   // 0 done, 1 err, 2 abort
      int cyc;
      int lvl;
      int made;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [CW-1:0] cups;
   logic          abort;
   logic [3:0]    state;
   logic          busy;
   logic          done;
   logic          err;
   logic [LW-1:0] level;
   logic [CW-1:0] cups_made;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   m_level = 0;
   int   m_made = 0;
   exp_t q[$];
   exp_t mon_e;
   int   mon_kind;
   logic prev_done = 1'b0;

   maquina_cafe_param #(
      .STEP_CYCLES(S),
      .RES_CAP    (CAP),
      .CUP_COST   (COST),
      .FILL_RATE  (FR),
      .MAX_CUPS   (MAXC),
      .CUPS_W     (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cups     (cups),
      .abort    (abort),
      .state    (state),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .level    (level),
      .cups_made(cups_made)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int cups_at(input int j, input int d, input int n);
      int c;
      if (j < d) return 0;
      c = (j - d) / S;
      return (c > n) ? n : c;
   endfunction

   // Reservoir level visible j cycles after the start edge.
   function automatic int lvl_at(input int j, input int l0, input int k, input int lf,
                                 input int d, input int n);
      if (j >= d) return lf - cups_at(j, d, n) * COST;
      if (k > 0 && j >= S + 1 && j <= S + k) return l0 + (j - S - 1) * FR;
      if (k > 0 && j > S + k) return CAP;
      return l0;
   endfunction

   // mode: 0 run to completion, 1 abort at a random point, 2 abort while grinding
   task automatic brew(input int n, input int mode);
      int l0, k, lf, d, f, j, end_off, e0;
      exp_t e;
      l0 = m_level;
      k  = 0;
      lf = l0;
      if (l0 < n * COST) begin
         k  = ceil_div(CAP - l0, FR);
         lf = CAP;
      end
      d = 5 * S + 1 + ((k > 0) ? k + 1 : 0);
      f = d + n * S;
      if (mode == 1)      j = $urandom_range(0, f - 1);
      else if (mode == 2) j = d - 4 * S;
      else                j = -1;
      @(negedge clk);
      start = 1'b1;
      cups  = CW'(n);
      abort = 1'b0;
      e0    = cyc + 1;
      if (j < 0) begin
         e = '{kind: 0, cyc: e0 + f, lvl: lf - n * COST, made: n};
         end_off = f + 1;
      end else begin
         e = '{kind: 2, cyc: e0 + j + 1, lvl: lvl_at(j, l0, k, lf, d, n), made: cups_at(j, d, n)};
         end_off = j + 2;
      end
      m_level = e.lvl;
      m_made  = e.made;
      q.push_back(e);
      for (int off = 0; off < end_off; off++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         cups  = CW'($urandom_range(0, 7));
         abort = (off == j) || (j < 0 && off == f && $urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic illegal(input int v);
      @(negedge clk);
      start = 1'b1;
      cups  = CW'(v);
      abort = ($urandom_range(0, 1) == 1);
      q.push_back('{kind: 1, cyc: cyc + 1, lvl: m_level, made: m_made});
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("err_single_cycle", err, 0);
      check("idle_after_err", state, 0);
      check("busy_after_err", busy, 0);
   endtask

   task automatic reset_during_fill();
      @(negedge clk);
      start = 1'b1;
      cups  = CW'(2);
      @(negedge clk);
      start = 1'b0;
      repeat (S + 2) @(negedge clk);
      check("fill_state", state, 3);
      check("fill_level", level, m_level + FR);
      rst = 1'b1;
      @(negedge clk);
      check("rst_fill_state", state, 0);
      check("rst_fill_level", level, 0);
      check("rst_fill_made", cups_made, 0);
      check("rst_fill_busy", busy, 0);
      rst = 1'b0;
      m_level = 0;
      m_made  = 0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (prev_done) check("idle_after_final", state, 0);
         if (done || err || state == 4'd10) begin
            mon_kind = done ? 0 : (err ? 1 : 2);
            if (q.size() == 0 || q[0].kind != mon_kind) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: kind %0d at cycle %0d, expected kind %0d (queue %0d)",
                        mon_kind, cyc, (q.size() == 0) ? -1 : q[0].kind, q.size());
            end else begin
               mon_e = q.pop_front();
               check("event_cycle", cyc, mon_e.cyc);
               check("event_level", level, mon_e.lvl);
               check("event_cups_made", cups_made, mon_e.made);
               if (mon_kind == 0) check("final_state", state, 9);
               if (mon_kind == 1) check("err_state_idle", state, 0);
               if (mon_kind == 2) check("abort_no_done", done, 0);
            end
         end
         prev_done <= done;
      end else begin
         prev_done <= 1'b0;
      end
   end

   initial begin
      int r, v;
      rst   = 1'b1;
      start = 1'b0;
      cups  = '0;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_state", state, 0);
      check("rst_level", level, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_cups_made", cups_made, 0);
      rst = 1'b0;

      brew(1, 0);
      brew(3, 0);
      brew(2, 2);
      brew(4, 0);
      illegal(0);
      illegal(5);
      reset_during_fill();
      brew(4, 0);

      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 9);
         if (r < 2) begin
            v = $urandom_range(0, 3);
            illegal((v == 0) ? 0 : v + 4);
         end else if (r < 5) begin
            brew($urandom_range(1, MAXC), 1);
         end else begin
            brew($urandom_range(1, MAXC), 0);
         end
      end

      repeat (4) @(negedge clk);
      check("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/maquina_cafe_param.md
Name: maquina_cafe_param

Overview:
Parametrised successor of the team's coffee-machine sequencer FSM. It runs a multi-step brew sequence with configurable dwell time per step and a tracked reservoir water level. Each request brews N cups, refilling the reservoir only when water is short. It adds an abort input, a busy/done/err handshake and a cup counter. It sits under a top-level controller that issues start requests and watches the 4-bit state for display/LEDs.

Parameters:
STEP_CYCLES, 4, dwell cycles of each timed step (>=1)
RES_CAP, 8, reservoir capacity in water units
CUP_COST, 2, water units consumed per cup
FILL_RATE, 1, water units added per cycle while filling (>=1)
MAX_CUPS, 4, largest legal cups request
CUPS_W, 3, width of cups/cups_made (must hold MAX_CUPS)
Derived localparam LVL_W = clog2(RES_CAP+1). Elaboration check: MAX_CUPS*CUP_COST <= RES_CAP.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  brew request, sampled only in IDLE
cups  in  CUPS_W  cups requested, sampled with start
abort  in  1  cancel the running brew
state  out  4  current FSM state code
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, high while state == FINAL
err  out  1  one-cycle pulse: illegal cups on start
level  out  LVL_W  current reservoir level
cups_made  out  CUPS_W  cups poured in current/last brew

Behaviour:
- State codes: IDLE=0, LIGAR=1, VERIFICAR_AGUA=2, ENCHER_RESERVATORIO=3, MOER_CAFE=4, COLOCAR_NO_FILTRO=5, PASSAR_AGITADOR=6, ESQUENTAR_AGUA=7, DESPEJAR=8, FINAL=9, ABORTADO=10. Codes 11-15 are unused and go to IDLE.
- Reset (rst high at an edge) gives: state=IDLE, level=0, cups_made=0, done=0, err=0, busy=0, step counter=0. Reset mid-operation is the same, and water is lost.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- IDLE, start=1, 1<=cups<=MAX_CUPS: latch cups into cups_req, clear cups_made, go to LIGAR next edge.
- IDLE, start=1, cups=0 or cups>MAX_CUPS: err=1 for the next cycle only. Stay in IDLE.
- start outside IDLE is ignored.
- Timed steps (LIGAR, MOER_CAFE, COLOCAR_NO_FILTRO, PASSAR_AGITADOR, ESQUENTAR_AGUA, DESPEJAR):
  - Each occupies exactly STEP_CYCLES cycles.
  - The counter resets on every state entry.
- VERIFICAR_AGUA occupies 1 cycle.
  - If level >= cups_req*CUP_COST, go to MOER_CAFE.
  - Otherwise go to ENCHER_RESERVATORIO.
- ENCHER_RESERVATORIO: level += FILL_RATE each cycle, saturating at RES_CAP. In the cycle the update reaches RES_CAP, next state is VERIFICAR_AGUA.
- Sequence: LIGAR -> VERIFICAR_AGUA -> MOER_CAFE -> COLOCAR_NO_FILTRO -> PASSAR_AGITADOR -> ESQUENTAR_AGUA -> DESPEJAR.
- DESPEJAR, at the end of each STEP_CYCLES period: level -= CUP_COST and cups_made += 1.
  - If the new cups_made == cups_req, go to FINAL.
  - Otherwise stay in DESPEJAR and restart the counter.
- FINAL lasts 1 cycle (done=1), then IDLE.
- Latency, full water, defaults, start accepted at edge E0:
  - LIGAR visible E0..E3, VERIFICAR E4, MOER E5, DESPEJAR E21.
  - FINAL at E(21+4N).
  - Each needed fill adds ceil((RES_CAP-level)/FILL_RATE)+1 cycles.
- abort=1 in any state other than IDLE/FINAL/ABORTADO: next state ABORTADO for 1 cycle, then IDLE.
  - abort has priority over a step transition in the same cycle.
  - level and cups_made hold their values; done is not pulsed.
  - abort in IDLE, FINAL or ABORTADO is ignored.
- Water arithmetic is unsigned LVL_W. Underflow cannot occur, by the VERIFICAR check and the elaboration constraint.

Decomposition:
- Shared package maquina_pkg:
  - state enum/localparams (4-bit codes above) and their width.
  - default constants for STEP_CYCLES, RES_CAP, CUP_COST.
- One natural sub-module, step_timer: counter with load/clear on state change and a terminal-count pulse at STEP_CYCLES-1.
- Reservoir level and cup counter stay in the top FSM.

Test Plan:
- Reset values: rst=1 for 2 cycles -> state=0, level=0, busy=0, done=0, err=0, cups_made=0.
- First brew from empty: start with cups=1 -> passes through state 3 for 8 cycles, level rises 0..8 and drops to 6 in DESPEJAR; FINAL at E34; done 1 cycle; cups_made=1.
- Brew without refill: level=6, start with cups=3 -> state 3 never entered; FINAL at E33; level=0; cups_made=3.
- Abort mid-step: abort=1 during MOER_CAFE -> state 10 for one cycle, then 0; done stays 0; level unchanged.
- Illegal request: start with cups=0, then with cups=5 -> err pulses one cycle each; state stays 0; busy=0.
- Reset during ENCHER_RESERVATORIO: rst=1 -> next cycle state=0, level=0. A new start with cups=4 fills to 8 and ends with level=0, cups_made=4.
